// File: rtl/fetch_pkg.sv
// +----------------------------------------------------------------------------+
// | fetch_pkg : shared widths, HALT encoding and queue entry type for fetch    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package fetch_pkg;

  localparam int ADDR_W_DEFAULT = 10;
  localparam int DATA_W_DEFAULT = 16;

  localparam logic [15:0] HALT_WORD = 16'hF000;

  typedef struct packed {
    logic [DATA_W_DEFAULT-1:0] instr;
    logic [ADDR_W_DEFAULT-1:0] pc;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// +----------------------------------------------------------------------------+
// | fetch_queue : synchronous prefetch FIFO with push/pop/flush, full/empty    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module fetch_queue
  import fetch_pkg::*;
#(
  parameter int  QDEPTH  = 2,
  parameter type entry_t = fetch_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  input  logic   flush,
  output logic   full,
  output logic   empty,
  output entry_t head
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH + 1);

  entry_t             mem_q [QDEPTH];
  entry_t             mem_d [QDEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push;
  logic               do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(QDEPTH));
  assign do_pop  = pop && !empty;
  // A full queue still accepts a push when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// +----------------------------------------------------------------------------+
// | instr_fetch : PC sequencer feeding a prefetch queue toward decode.         |
// | Optional HALT-word stop enabled by macro FETCH_HALT_EN.                    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module instr_fetch
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEFAULT,
  parameter int                DATA_W   = DATA_W_DEFAULT,
  parameter int                QDEPTH   = 2,              // legal range 1..8
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] instr_address,
  input  logic [DATA_W-1:0] instr_out,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted
);

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              q_full;
  logic              q_empty;
  entry_t            q_head;
  entry_t            push_entry;
  logic              deq;
  logic              push;
  logic              fetch_stop;

  assign instr_address = pc_q;
  assign out_valid     = !q_empty && !redirect_valid;
  assign out_instr     = q_head.instr;
  assign out_pc        = q_head.pc;
  assign deq           = out_valid && out_ready;
  assign push          = !redirect_valid && !fetch_stop && (!q_full || deq);
  assign push_entry    = '{instr: instr_out, pc: pc_q};

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (push) begin
      pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

`ifdef FETCH_HALT_EN
  logic halted_q, halted_d;

  always_comb begin
    halted_d = halted_q;
    if (redirect_valid) begin
      halted_d = 1'b0;
    end else if (push && (instr_out == DATA_W'(HALT_WORD))) begin
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  assign fetch_stop = halted_q;
  assign halted     = halted_q;
`else
  assign fetch_stop = 1'b0;
  assign halted     = 1'b0;
`endif

  fetch_queue #(
    .QDEPTH  (QDEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (deq),
    .flush     (redirect_valid),
    .full      (q_full),
    .empty     (q_empty),
    .head      (q_head)
  );

endmodule

`default_nettype wire
